// File: rtl/da_z2_engine.sv
// da_z2_engine: distributed-arithmetic engine for the DCT z2 partial output.
// The engine shifts the four samples out LSB-first and uses the bits to address
// the z2 coefficient ROM. Each returned Q2.14 word is shift-accumulated into a
// full-precision result. Bit 0 of x0 folds the table: when it is set, the address
// is inverted and the ROM word is negated. This halves the ROM to 8 words.
module da_z2_engine #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int AW = DW + CW + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x0,
    input  logic signed [DW-1:0] x1,
    input  logic signed [DW-1:0] x2,
    input  logic signed [DW-1:0] x3,
    output logic                 rom_cs,
    output logic [2:0]           rom_addr,
    input  logic signed [CW-1:0] rom_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] z
);

    localparam int CNTW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(DW - 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [DW-1:0]         s0_q, s0_d;
    logic [DW-1:0]         s1_q, s1_d;
    logic [DW-1:0]         s2_q, s2_d;
    logic [DW-1:0]         s3_q, s3_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [AW-1:0]  z_q, z_d;
    logic                  rom_cs_q, rom_cs_d;
    logic [2:0]            rom_addr_q, rom_addr_d;
    logic                  neg_q, neg_d;

    logic                  accept;
    logic                  last_bit;
    logic signed [AW-1:0]  term;
    logic signed [AW-1:0]  term_shifted;

    // Fold one bit-slice into {neg, addr}. When b0 is set, the complementary
    // address is used and the ROM word is negated.
    function automatic logic [3:0] fold_bits(input logic b0, input logic b1,
                                             input logic b2, input logic b3);
        if (b0) begin
            fold_bits = {1'b1, ~{b1, b2, b3}};
        end else begin
            fold_bits = {1'b0, b1, b2, b3};
        end
    endfunction

    assign accept   = start && in_ready;
    assign last_bit = (cnt_q == LAST_BIT);

    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;
    assign z        = z_q;

    // State register, cleared to WAIT on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one settling cycle, then the accept / run / handshake loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: state_d = S_IDLE;
            S_IDLE: if (accept)    state_d = S_RUN;
            S_RUN:  if (last_bit)  state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_WAIT;
        endcase
    end

    // Handshake outputs decoded directly from the state.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    // Datapath: load on accept, then one shift-accumulate step per bit.
    // The final bit has negative weight (two's complement sign), so it is subtracted.
    always_comb begin
        s0_d       = s0_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        s3_d       = s3_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        z_d        = z_q;
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        neg_d      = neg_q;

        term = AW'(rom_data);
        if (neg_q) begin
            term = -term;
        end
        term_shifted = term <<< cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    s0_d                = {1'b0, x0[DW-1:1]};
                    s1_d                = {1'b0, x1[DW-1:1]};
                    s2_d                = {1'b0, x2[DW-1:1]};
                    s3_d                = {1'b0, x3[DW-1:1]};
                    acc_d               = '0;
                    cnt_d               = '0;
                    rom_cs_d            = 1'b1;
                    {neg_d, rom_addr_d} = fold_bits(x0[0], x1[0], x2[0], x3[0]);
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    acc_d      = acc_q - term_shifted;
                    z_d        = acc_q - term_shifted;
                    rom_cs_d   = 1'b0;
                    rom_addr_d = 3'b000;
                    neg_d      = 1'b0;
                end else begin
                    acc_d               = acc_q + term_shifted;
                    cnt_d               = cnt_q + 1'b1;
                    {neg_d, rom_addr_d} = fold_bits(s0_q[0], s1_q[0], s2_q[0], s3_q[0]);
                    s0_d                = {1'b0, s0_q[DW-1:1]};
                    s1_d                = {1'b0, s1_q[DW-1:1]};
                    s2_d                = {1'b0, s2_q[DW-1:1]};
                    s3_d                = {1'b0, s3_q[DW-1:1]};
                end
            end
            default: ;
        endcase
    end

    // Datapath registers. Reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q       <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            z_q        <= '0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= 3'b000;
            neg_q      <= 1'b0;
        end else begin
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            z_q        <= z_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            neg_q      <= neg_d;
        end
    end

endmodule

// File: tb/tb_da_z2_engine.sv
// Testbench for da_z2_engine. It drives directed sample sets and models the z2
// coefficient ROM. A scoreboard queue is checked by an independent output monitor.
module tb_da_z2_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               in_ready;
    logic signed [15:0] x0, x1, x2, x3;
    logic               rom_cs;
    logic [2:0]         rom_addr;
    logic signed [15:0] rom_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [33:0] z;

    int n_vectors = 0;
    int n_miscompares = 0;
    logic signed [33:0] z_queue[$];

    da_z2_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // z2 coefficient ROM model in Q2.14. Address bits are {x1, x2, x3}.
    // The weights are x1 = -6270, x2 = +6269, and x3 = +15137.
    function automatic logic signed [15:0] rom_model(input logic [2:0] a);
        case (a)
            3'd0:    rom_model = 16'sd0;
            3'd1:    rom_model = 16'sd15137;
            3'd2:    rom_model = 16'sd6269;
            3'd3:    rom_model = 16'sd21406;
            3'd4:    rom_model = -16'sd6270;
            3'd5:    rom_model = 16'sd8867;
            3'd6:    rom_model = -16'sd1;
            default: rom_model = 16'sd15136;
        endcase
    endfunction

    assign rom_data = rom_cs ? rom_model(rom_addr) : 16'sd0;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Output monitor: pops the scoreboard whenever a result is handed over.
    always @(negedge clk) begin
        logic signed [33:0] exp_z;
        #2;
        if (!rst && out_valid && out_ready) begin
            if (z_queue.size() == 0) begin
                n_vectors++;
                n_miscompares++;
                $display("[TB] FAIL unexpected_result: got z=%0d, expected no result", z);
            end else begin
                exp_z = z_queue.pop_front();
                checkOutput("z", z, exp_z);
            end
        end
    end

    // One operation: accept, check latency/ROM activity, optionally stall, then release.
    task automatic applyStimulus(input logic signed [15:0] a0, input logic signed [15:0] a1,
                                 input logic signed [15:0] a2, input logic signed [15:0] a3,
                                 input logic signed [33:0] exp_z, input int hold_cycles,
                                 input bit check_addr, input logic [2:0] addr_first,
                                 input logic [2:0] addr_rest);
        int wait_cnt;
        int cycles;
        int cs_count;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        checkOutput("in_ready_before_start", in_ready, 1);
        x0 = a0;
        x1 = a1;
        x2 = a2;
        x3 = a3;
        start = 1'b1;
        out_ready = (hold_cycles == 0);
        @(posedge clk);
        z_queue.push_back(exp_z);
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        cs_count = 0;
        while (!out_valid && cycles < 40) begin
            if (rom_cs) begin
                if (check_addr) begin
                    checkOutput("rom_addr", rom_addr, (cs_count == 0) ? addr_first : addr_rest);
                end
                cs_count++;
            end
            @(negedge clk);
            cycles++;
        end
        checkOutput("latency", cycles, 17);
        checkOutput("rom_cs_cycles", cs_count, 16);
        for (int h = 0; h < hold_cycles; h++) begin
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_z", z, exp_z);
            checkOutput("hold_in_ready", in_ready, 0);
            x0 = 16'sd1234;
            x1 = -16'sd77;
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("out_valid_drop", out_valid, 0);
        checkOutput("in_ready_after", in_ready, 1);
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        x0 = '0;
        x1 = '0;
        x2 = '0;
        x3 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_rom_cs", rom_cs, 0);
        checkOutput("reset_rom_addr", rom_addr, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_z", z, 0);
        rst = 1'b0;
        #1;
        checkOutput("wait_in_ready", in_ready, 0);
        @(negedge clk);
        checkOutput("idle_in_ready", in_ready, 1);
        checkOutput("idle_rom_cs", rom_cs, 0);
        checkOutput("idle_out_valid", out_valid, 0);

        applyStimulus(16'sd0, 16'sd0, 16'sd1, 16'sd0, 34'sd6269, 0, 1'b1, 3'b010, 3'b000);
        applyStimulus(16'sd0, 16'sd1, 16'sd0, 16'sd0, -34'sd6270, 0, 1'b0, 3'b000, 3'b000);
        applyStimulus(16'sd0, 16'sd1, 16'sd1, 16'sd0, -34'sd1, 0, 1'b0, 3'b000, 3'b000);
        applyStimulus(16'sd0, 16'sd0, -16'sd1, 16'sd0, -34'sd6269, 0, 1'b1, 3'b010, 3'b010);
        applyStimulus(16'sd0, 16'sd0, 16'sd32767, 16'sd0, 34'sd205416323, 0, 1'b0, 3'b000, 3'b000);
        applyStimulus(16'sd0, -16'sd32768, -16'sd32768, 16'sd0, 34'sd32768, 0, 1'b0, 3'b000, 3'b000);
        applyStimulus(16'sd1, 16'sd0, 16'sd0, 16'sd0, -34'(rom_model(3'b111)), 0,
                      1'b1, 3'b111, 3'b000);
        applyStimulus(16'sd1, 16'sd1, 16'sd0, 16'sd0, -34'sd21406, 0, 1'b1, 3'b011, 3'b000);
        applyStimulus(16'sd0, 16'sd0, 16'sd0, 16'sd2, 34'sd30274, 5, 1'b0, 3'b000, 3'b000);

        // Reset in the middle of a run at bit 7; no result may appear.
        x0 = 16'sd5;
        x1 = 16'sd9;
        x2 = -16'sd3;
        x3 = 16'sd100;
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("midrun_rom_cs", rom_cs, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrun_reset_rom_cs", rom_cs, 0);
        checkOutput("midrun_reset_out_valid", out_valid, 0);
        checkOutput("midrun_reset_in_ready", in_ready, 0);
        checkOutput("midrun_reset_z", z, 0);
        rst = 1'b0;
        #1;
        checkOutput("midrun_wait_in_ready", in_ready, 0);
        @(negedge clk);
        checkOutput("midrun_idle_in_ready", in_ready, 1);
        repeat (20) begin
            @(negedge clk);
            if (out_valid || rom_cs) begin
                checkOutput("midrun_no_activity", {out_valid, rom_cs}, 0);
            end
        end

        applyStimulus(16'sd0, 16'sd0, 16'sd0, -16'sd1, -34'sd15137, 0, 1'b1, 3'b001, 3'b001);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", z_queue.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/da_z2_engine.md
Name: da_z2_engine

Overview:
- Distributed-arithmetic (DA) engine that computes the DCT z2 partial output from four signed input samples x0..x3.
- It is the requester on the z2 coefficient ROM interface. It serialises the inputs LSB-first, drives the ROM chip-select and 3-bit address each cycle, and shift-accumulates the returned 16-bit Q2.14 words into a full-precision result.
- It sits between the DCT input staging and the z2 output scaling stage.
- Implemented weights: x0 = -c2, x1 = -c6, x2 = +c6, x3 = +c2.

Parameters:
- DW, 16, input sample width (signed two's complement).
- CW, 16, ROM word width (Q2.14 signed).
- AW, DW+CW+2, accumulator/result width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset. The ROM is fed rst_n = ~rst at top level.
- start  in  1  request; accepted when start && in_ready.
- in_ready  out  1  engine can accept a new sample set.
- x0, x1, x2, x3  in  DW each  signed samples, sampled on the accept edge only.
- rom_cs  out  1  ROM chip select (registered).
- rom_addr  out  3  ROM address (registered).
- rom_data  in  CW  ROM word. Combinational from rom_addr in the same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result when out_valid && out_ready.
- z  out  AW  signed result, Q(AW-14).14. The 0.5 DCT scale is not applied here.

Behaviour:
- Reset values: in_ready=0, rom_cs=0, rom_addr=0, out_valid=0, z=0, acc=0, bit counter=0, state=WAIT.
- States and transitions:
  - WAIT: exactly one cycle after rst deasserts; the ROM still outputs 0 in this cycle. Next state IDLE.
  - IDLE: in_ready=1. On accept, load shift registers s0..s3 from x0..x3, clear acc, cnt=0. Register rom_cs=1, rom_addr and neg from bit 0. Next state RUN.
  - RUN: exactly DW cycles, j=0..DW-1.
  - DONE: out_valid=1; z holds.
- Address/sign folding per bit j, with bits bk = sk[j]:
  - If b0=0: rom_addr={b1,b2,b3}, neg=0.
  - If b0=1: rom_addr=~{b1,b2,b3}, neg=1.
- Per RUN cycle j:
  - term = neg ? -rom_data : rom_data, sign-extended to AW.
  - acc += term<<j for j<DW-1; acc -= term<<(DW-1) for j=DW-1 (sign bit).
  - Registered rom_addr/neg advance to bit j+1.
- Leaving RUN at j=DW-1: z <= final acc value, rom_cs <= 0, rom_addr <= 0, state <= DONE.
- Latency: start accepted in cycle 0 → out_valid high in cycle DW+1 (17 by default).
- rom_cs is high for exactly DW consecutive cycles per operation and 0 otherwise.
- DONE exit: on out_ready, out_valid drops next edge, state IDLE, in_ready=1. in_ready is never high in RUN or DONE (no overlap); start outside IDLE is ignored.
- If out_ready is already high when DONE is entered, out_valid stays high exactly one cycle.
- z changes only when leaving RUN. It holds its value in IDLE until the next result.
- Reset mid-RUN or mid-DONE: next edge returns all reset values and enters WAIT. The partial result is discarded.
- Arithmetic: no saturation or rounding. AW is sized so that |sum| ≤ 2*(c2+c6)*2^(DW-1)*2^14 cannot overflow.

Test Plan:
- Reset release: rst 1→0 → in_ready=0 for one cycle, then 1. rom_cs=0 and out_valid=0 throughout.
- x2=1, others 0 → rom_addr=3'b010 at j=0 only, z=6269, out_valid exactly 17 cycles after accept, rom_cs high for 16 cycles.
- x1=1, others 0 → z=-6270. Then x1=1, x2=1 → z=-1.
- x2=-1, others 0 → rom_addr=3'b010 all 16 cycles, z=-6269. Then x2=32767 → z=205416323.
- x1=x2=-32768, x0=x3=0 → z=32768 (sign-bit subtraction path). x0=1 alone → z equals -(ROM word at 3'b111), checked against the ROM model.
- Hold out_ready=0 for 5 cycles in DONE → z and out_valid stable, start ignored. Assert rst during RUN j=7 → rom_cs=0 next cycle, no out_valid, normal operation after WAIT.
